// File: rtl/aes_spi_pkg.sv
// Shared types and sizing helpers for the AES SPI frame slave.
//   state_t : frame FSM states
//   MSG_W   : message/result width in bits
//   key_w() : key width for a given NK (32-bit words)
//   cnt_w() : bit counter width able to hold 0..MSG_W+KEY_W
package aes_spi_pkg;

  localparam int unsigned MSG_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_START,
    ST_WAIT,
    ST_READY,
    ST_TX,
    ST_DONE
  } state_t;

  function automatic int unsigned key_w(input int unsigned nk);
    return 32 * nk;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned nk);
    return $clog2(MSG_W + 32 * nk + 1);
  endfunction

endpackage

// File: rtl/aes_spi_tx_shifter.sv
// Result serialiser: parallel load of the 128-bit core result, shift right
// one bit per enable, registered miso that reads 0 whenever not shifting.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture data into the shift register
//   shift      : present the current LSB on miso and advance
//   data       : parallel result input
//   miso       : registered serial output
module aes_spi_tx_shifter
  import aes_spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [MSG_W-1:0] data,
  output logic             miso
);

  logic [MSG_W-1:0] shreg;

  // Load has priority; the top never asserts both in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      miso  <= 1'b0;
    end else begin
      miso <= shift ? shreg[0] : 1'b0;
      if (load) begin
        shreg <= data;
      end else if (shift) begin
        shreg <= {1'b0, shreg[MSG_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/aes_spi_frame_slave.sv
// Serial front end of the AES engine. Deserialises a frame of 128 message
// bits followed by 32*NK key bits (LSB first) from mosi, pulses core_start,
// waits for core_done, then streams the result LSB first on miso once the
// master selects readout mode.
//   clk, reset           : clock, synchronous active-high reset
//   cs_n, mosi, mode     : frame select, serial data, 0=load / 1=readout
//   miso                 : registered serial result
//   core_start           : one-cycle launch pulse to the AES core
//   core_msg, core_key   : assembled operands, held until the next frame
//   core_done            : one-cycle completion pulse from the core
//   core_result          : core output, valid with core_done
//   busy                 : frame in progress (RX through TX)
//   frame_err            : sticky abort flag, cleared at next frame start
module aes_spi_frame_slave
  import aes_spi_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              mode,
  output logic              miso,
  output logic              core_start,
  output logic [MSG_W-1:0]  core_msg,
  output logic [32*NK-1:0]  core_key,
  input  logic              core_done,
  input  logic [MSG_W-1:0]  core_result,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned KEY_W  = key_w(NK);
  localparam int unsigned CNT_W  = cnt_w(NK);
  localparam int unsigned TOTAL  = MSG_W + KEY_W;
  localparam int unsigned MIDX_W = $clog2(MSG_W);
  localparam int unsigned KIDX_W = $clog2(KEY_W);

  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [MIDX_W-1:0] msg_idx;
  logic [KIDX_W-1:0] key_idx;
  logic              tx_load;
  logic              tx_shift;

  // Saturating increment and bit-position decode for the deserialiser.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign msg_idx = MIDX_W'(cnt);
  assign key_idx = KIDX_W'(cnt - CNT_W'(MSG_W));

  // Shifter controls; an abort (cs_n high) suppresses both, so a result
  // arriving together with a cs_n rise is discarded.
  always_comb begin
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    if (!cs_n) begin
      tx_load  = (state == ST_WAIT) && core_done;
      tx_shift = ((state == ST_READY) && mode) ||
                 ((state == ST_TX) && (cnt != LAST_TX));
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      core_start <= 1'b0;
      core_msg   <= '0;
      core_key   <= '0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_n) begin
            // First low cycle of cs_n already carries frame bit 0.
            state       <= ST_RX;
            busy        <= 1'b1;
            frame_err   <= 1'b0;
            core_msg[0] <= mosi;
            cnt         <= CNT_W'(1);
          end
        end
        ST_RX: begin
          if (cs_n || mode) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            cnt       <= '0;
          end else begin
            if (cnt < CNT_W'(MSG_W)) begin
              core_msg[msg_idx] <= mosi;
            end else begin
              core_key[key_idx] <= mosi;
            end
            cnt <= cnt_inc;
            if (cnt == LAST_RX) begin
              state      <= ST_START;
              core_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          if (cs_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            cnt       <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cs_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            cnt       <= '0;
          end else if (core_done) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (cs_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            cnt       <= '0;
          end else if (mode) begin
            // cnt now tracks the index of the bit currently on miso.
            state <= ST_TX;
            cnt   <= '0;
          end
        end
        ST_TX: begin
          if (cs_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            cnt       <= '0;
          end else if (cnt == LAST_TX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          if (cs_n) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  aes_spi_tx_shifter u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .shift (tx_shift),
    .data  (core_result),
    .miso  (miso)
  );

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// Directed self-checking bench for aes_spi_frame_slave (NK=4 and NK=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aes_spi_frame_slave;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // NK = 4 instance
  logic         cs_n4, mosi4, mode4, miso4, start4, done4, busy4, err4;
  logic [127:0] msg4, key4, result4;

  // NK = 8 instance
  logic         cs_n8, mosi8, mode8, miso8, start8, done8, busy8, err8;
  logic [127:0] msg8, result8;
  logic [255:0] key8;

  aes_spi_frame_slave #(.NK(4)) dut4 (
    .clk(clk), .reset(reset), .cs_n(cs_n4), .mosi(mosi4), .mode(mode4),
    .miso(miso4), .core_start(start4), .core_msg(msg4), .core_key(key4),
    .core_done(done4), .core_result(result4), .busy(busy4), .frame_err(err4)
  );

  aes_spi_frame_slave #(.NK(8)) dut8 (
    .clk(clk), .reset(reset), .cs_n(cs_n8), .mosi(mosi8), .mode(mode8),
    .miso(miso8), .core_start(start8), .core_msg(msg8), .core_key(key8),
    .core_done(done8), .core_result(result8), .busy(busy8), .frame_err(err8)
  );

  localparam logic [127:0] MSG1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RES1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MSG2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RES2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int start_cnt4 = 0;

  always @(negedge clk) if (start4 === 1'b1) start_cnt4++;

  // Drive nbits frame bits; optionally pulse a spurious core_done at one bit.
  task automatic send4(input logic [255:0] bits, input int nbits, input int spur_at);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cs_n4   = 1'b0;
      mosi4   = bits[i];
      done4   = (i == spur_at);
      result4 = (i == spur_at) ? {4{32'hdeadbeef}} : 128'h0;
    end
  endtask

  // Core model: done pulse lat cycles after the START cycle; returns in READY.
  task automatic core4(input logic [127:0] r, input int lat);
    repeat (lat) @(negedge clk);
    done4   = 1'b1;
    result4 = r;
    @(negedge clk);
    done4   = 1'b0;
    result4 = 128'h0;
  endtask

  task automatic read_tx4(output logic [127:0] got);
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      got[n] = miso4;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++;
    if ({miso4, start4, busy4, err4} !== 4'b0) $display("FAIL rst_flags4 got=%b want=0000", {miso4, start4, busy4, err4});
    else pass_cnt++;
    total_cnt++;
    if ({msg4, key4} !== 256'h0) $display("FAIL rst_data4 got=%h want=0", {msg4, key4});
    else pass_cnt++;
    total_cnt++;
    if ({miso8, start8, busy8, err8, msg8, key8} !== 388'h0) $display("FAIL rst_all8 got=%h want=0", {miso8, start8, busy8, err8, msg8, key8});
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_nominal;
    logic [127:0] got;
    int base;
    base = start_cnt4;
    send4({KEY1, MSG1}, 256, -1);
    @(negedge clk);
    mosi4 = 1'b0;
    total_cnt++;
    if (start4 !== 1'b1) $display("FAIL nom_start got=%b want=1", start4);
    else pass_cnt++;
    total_cnt++;
    if (msg4 !== MSG1) $display("FAIL nom_msg got=%h want=%h", msg4, MSG1);
    else pass_cnt++;
    total_cnt++;
    if (key4 !== KEY1) $display("FAIL nom_key got=%h want=%h", key4, KEY1);
    else pass_cnt++;
    core4(RES1, 10);
    mode4 = 1'b1;
    read_tx4(got);
    total_cnt++;
    if (got !== RES1) $display("FAIL nom_miso got=%h want=%h", got, RES1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy4, miso4} !== 2'b00) $display("FAIL nom_done busy,miso got=%b want=00", {busy4, miso4});
    else pass_cnt++;
    total_cnt++;
    if (start_cnt4 - base !== 1) $display("FAIL nom_start_count got=%0d want=1", start_cnt4 - base);
    else pass_cnt++;
    total_cnt++;
    if (err4 !== 1'b0) $display("FAIL nom_err got=%b want=0", err4);
    else pass_cnt++;
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic [127:0] got;
    int base;
    base = start_cnt4;
    send4({KEY1, MSG1}, 101, -1);
    @(negedge clk);
    cs_n4 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({err4, busy4} !== 2'b10) $display("FAIL abort_cs err,busy got=%b want=10", {err4, busy4});
    else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (start_cnt4 - base !== 0) $display("FAIL abort_no_start got=%0d want=0", start_cnt4 - base);
    else pass_cnt++;
    // mode high during RX also aborts
    send4({KEY1, MSG1}, 31, -1);
    @(negedge clk);
    mode4 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({err4, busy4} !== 2'b10) $display("FAIL abort_mode err,busy got=%b want=10", {err4, busy4});
    else pass_cnt++;
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
    // following valid frame clears the flag and completes
    send4({KEY2, MSG2}, 256, -1);
    @(negedge clk);
    total_cnt++;
    if (err4 !== 1'b0) $display("FAIL abort_err_clear got=%b want=0", err4);
    else pass_cnt++;
    core4(RES2, 6);
    mode4 = 1'b1;
    read_tx4(got);
    total_cnt++;
    if (got !== RES2) $display("FAIL abort_next_miso got=%h want=%h", got, RES2);
    else pass_cnt++;
    total_cnt++;
    if (start_cnt4 - base !== 1) $display("FAIL abort_start_count got=%0d want=1", start_cnt4 - base);
    else pass_cnt++;
    @(negedge clk);
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ready_hold;
    logic [127:0] got;
    logic hold_ok;
    send4({KEY1, MSG1}, 256, -1);
    @(negedge clk);
    core4(RES1, 5);
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (miso4 !== 1'b0 || busy4 !== 1'b1) hold_ok = 1'b0;
    end
    total_cnt++;
    if (hold_ok !== 1'b1) $display("FAIL hold_ready got=%b want=1", hold_ok);
    else pass_cnt++;
    mode4 = 1'b1;
    @(negedge clk);
    got[0] = miso4;
    total_cnt++;
    if (miso4 !== RES1[0]) $display("FAIL hold_first_bit got=%b want=%b", miso4, RES1[0]);
    else pass_cnt++;
    for (int n = 1; n < 128; n++) begin
      @(negedge clk);
      got[n] = miso4;
    end
    total_cnt++;
    if (got !== RES1) $display("FAIL hold_miso got=%h want=%h", got, RES1);
    else pass_cnt++;
    @(negedge clk);
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_tx;
    logic [127:0] got;
    send4({KEY1, MSG1}, 256, -1);
    @(negedge clk);
    core4(RES1, 4);
    mode4 = 1'b1;
    for (int n = 0; n <= 60; n++) @(negedge clk);
    total_cnt++;
    if (miso4 !== RES1[60]) $display("FAIL rtx_bit60 got=%b want=%b", miso4, RES1[60]);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({miso4, start4, busy4, err4} !== 4'b0) $display("FAIL rtx_flags got=%b want=0000", {miso4, start4, busy4, err4});
    else pass_cnt++;
    total_cnt++;
    if ({msg4, key4} !== 256'h0) $display("FAIL rtx_data got=%h want=0", {msg4, key4});
    else pass_cnt++;
    reset = 1'b0;
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    send4({KEY2, MSG2}, 256, -1);
    @(negedge clk);
    total_cnt++;
    if ({msg4, key4} !== {MSG2, KEY2}) $display("FAIL rtx_next_data got=%h want=%h", {msg4, key4}, {MSG2, KEY2});
    else pass_cnt++;
    core4(RES2, 3);
    mode4 = 1'b1;
    read_tx4(got);
    total_cnt++;
    if (got !== RES2) $display("FAIL rtx_next_miso got=%h want=%h", got, RES2);
    else pass_cnt++;
    @(negedge clk);
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_and_wait_mode;
    logic [127:0] got;
    int base;
    base = start_cnt4;
    send4({KEY2, MSG2}, 256, 50);
    @(negedge clk);
    total_cnt++;
    if (start4 !== 1'b1) $display("FAIL spur_start got=%b want=1", start4);
    else pass_cnt++;
    total_cnt++;
    if ({msg4, key4} !== {MSG2, KEY2}) $display("FAIL spur_data got=%h want=%h", {msg4, key4}, {MSG2, KEY2});
    else pass_cnt++;
    @(negedge clk);
    mode4 = 1'b1;
    core4(RES2, 3);
    read_tx4(got);
    total_cnt++;
    if (got !== RES2) $display("FAIL wait_mode_miso got=%h want=%h", got, RES2);
    else pass_cnt++;
    total_cnt++;
    if ({err4, 32'(start_cnt4 - base)} !== {1'b0, 32'd1}) $display("FAIL spur_err_starts got=%b/%0d want=0/1", err4, start_cnt4 - base);
    else pass_cnt++;
    @(negedge clk);
    cs_n4 = 1'b1;
    mode4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nk8;
    logic [383:0] bits;
    bits = {KEY8, MSG2};
    for (int i = 0; i < 384; i++) begin
      @(negedge clk);
      if (i == 383) begin
        total_cnt++;
        if (start8 !== 1'b0) $display("FAIL nk8_early_start got=%b want=0", start8);
        else pass_cnt++;
      end
      cs_n8 = 1'b0;
      mosi8 = bits[i];
    end
    @(negedge clk);
    total_cnt++;
    if (start8 !== 1'b1) $display("FAIL nk8_start got=%b want=1", start8);
    else pass_cnt++;
    total_cnt++;
    if (key8 !== KEY8) $display("FAIL nk8_key got=%h want=%h", key8, KEY8);
    else pass_cnt++;
    total_cnt++;
    if (msg8 !== MSG2) $display("FAIL nk8_msg got=%h want=%h", msg8, MSG2);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (start8 !== 1'b0) $display("FAIL nk8_pulse_width got=%b want=0", start8);
    else pass_cnt++;
    cs_n8 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({err8, busy8} !== 2'b10) $display("FAIL nk8_wait_abort err,busy got=%b want=10", {err8, busy8});
    else pass_cnt++;
  endtask

  initial begin
    reset   = 1'b1;
    cs_n4   = 1'b1; mosi4 = 1'b0; mode4 = 1'b0; done4 = 1'b0; result4 = 128'h0;
    cs_n8   = 1'b1; mosi8 = 1'b0; mode8 = 1'b0; done8 = 1'b0; result8 = 128'h0;
    test_reset;
    test_nominal;
    test_abort;
    test_ready_hold;
    test_reset_mid_tx;
    test_spurious_and_wait_mode;
    test_nk8;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
